// File: rtl/redmule_tile_pkg.sv
// Core data port request/response types shared across the RedMulE tile.
package redmule_tile_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
        logic [5:0]  atop;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        exokay;
    } core_data_rsp_t;

endpackage

// File: rtl/core_data_amo_adapter.sv
// Bridges the core OBI data port onto the core-side TCDM port. Plain accesses pass straight
// through; atomics become a locked read-then-write with one LR/SC reservation. Out-of-range
// addresses and malformed atomics are answered locally with an error.
module core_data_amo_adapter
    import redmule_tile_pkg::*;
#(
    parameter logic [31:0] L1_BASE = 32'h1000_0000,
    parameter logic [31:0] L1_SIZE = 32'h0010_0000,
    parameter bit          RESV_EN = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  core_data_req_t core_data_req_i,
    output core_data_rsp_t core_data_rsp_o,
    output logic           tcdm_req_o,
    input  logic           tcdm_gnt_i,
    output logic [31:0]    tcdm_add_o,
    output logic           tcdm_wen_o,
    output logic [3:0]     tcdm_be_o,
    output logic [31:0]    tcdm_data_o,
    input  logic [31:0]    tcdm_r_data_i,
    input  logic           tcdm_r_valid_i
);

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpSwap = 5'b00001;
    localparam logic [4:0] OpLr   = 5'b00010;
    localparam logic [4:0] OpSc   = 5'b00011;
    localparam logic [4:0] OpXor  = 5'b00100;
    localparam logic [4:0] OpOr   = 5'b01000;
    localparam logic [4:0] OpAnd  = 5'b01100;
    localparam logic [4:0] OpMin  = 5'b10000;
    localparam logic [4:0] OpMax  = 5'b10100;
    localparam logic [4:0] OpMinu = 5'b11000;
    localparam logic [4:0] OpMaxu = 5'b11100;

    typedef enum logic [2:0] {
        StIdle, StAmoRd, StAmoWait, StAmoWr, StAmoWack, StAmoRsp
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;      // operand, replaced by the value to store once the read returns
    logic [31:0] rsp_data_q;
    logic [4:0]  op_q;
    logic        exokay_q;
    logic        resv_valid_q;
    logic [29:0] resv_addr_q;
    logic        plain_pend_q;
    logic        err_pend_q;

    logic [31:0] addr_off;
    logic        in_range;
    logic        atop_legal;
    logic        is_plain;
    logic        req_err;
    logic        resv_hit;
    logic [31:0] amo_new;
    logic        unused_fields;

    assign unused_fields = ^{core_data_req_i.memtype, core_data_req_i.prot, core_data_req_i.dbg};

    // Classify the incoming request: window hit, atop legality, error and reservation match.
    always_comb begin
        addr_off   = core_data_req_i.addr - L1_BASE;
        in_range   = addr_off < L1_SIZE;
        is_plain   = core_data_req_i.atop == 6'h00;
        atop_legal = is_plain;
        if (core_data_req_i.atop[5]) begin
            case (core_data_req_i.atop[4:0])
                OpAdd, OpSwap, OpXor, OpOr, OpAnd,
                OpMin, OpMax, OpMinu, OpMaxu: atop_legal = 1'b1;
                OpLr, OpSc:                   atop_legal = RESV_EN;
                default:                      atop_legal = 1'b0;
            endcase
        end
        req_err  = !in_range || !atop_legal ||
                   (!is_plain && (core_data_req_i.addr[1:0] != 2'b00 ||
                                  core_data_req_i.be != 4'hF));
        resv_hit = resv_valid_q && (resv_addr_q == core_data_req_i.addr[31:2]);
    end

    // New memory value from the word just read and the captured operand.
    always_comb begin
        amo_new = wdata_q;
        case (op_q)
            OpAdd:   amo_new = tcdm_r_data_i + wdata_q;
            OpXor:   amo_new = tcdm_r_data_i ^ wdata_q;
            OpOr:    amo_new = tcdm_r_data_i | wdata_q;
            OpAnd:   amo_new = tcdm_r_data_i & wdata_q;
            OpMin:   amo_new = ($signed(tcdm_r_data_i) < $signed(wdata_q)) ? tcdm_r_data_i : wdata_q;
            OpMax:   amo_new = ($signed(tcdm_r_data_i) > $signed(wdata_q)) ? tcdm_r_data_i : wdata_q;
            OpMinu:  amo_new = (tcdm_r_data_i < wdata_q) ? tcdm_r_data_i : wdata_q;
            OpMaxu:  amo_new = (tcdm_r_data_i > wdata_q) ? tcdm_r_data_i : wdata_q;
            default: amo_new = wdata_q;
        endcase
    end

    // Sequencer for atomics plus the one-cycle pending flags of the pass-through path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_data_q   <= '0;
            op_q         <= '0;
            exokay_q     <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            plain_pend_q <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            plain_pend_q <= 1'b0;
            err_pend_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (core_data_req_i.req) begin
                        if (req_err) begin
                            err_pend_q <= 1'b1;
                        end else if (is_plain) begin
                            if (tcdm_gnt_i) begin
                                plain_pend_q <= 1'b1;
                                if (core_data_req_i.we && resv_hit) resv_valid_q <= 1'b0;
                            end
                        end else begin
                            addr_q  <= core_data_req_i.addr;
                            op_q    <= core_data_req_i.atop[4:0];
                            wdata_q <= core_data_req_i.wdata;
                            if (core_data_req_i.atop[4:0] == OpSc) begin
                                // SC consumes the reservation whether or not it succeeds
                                resv_valid_q <= 1'b0;
                                exokay_q     <= resv_hit;
                                rsp_data_q   <= {31'b0, !resv_hit};
                                if (resv_hit) state_q <= StAmoWr;
                                else          state_q <= StAmoRsp;
                            end else begin
                                state_q <= StAmoRd;
                            end
                        end
                    end
                end
                StAmoRd: if (tcdm_gnt_i) state_q <= StAmoWait;
                StAmoWait: begin
                    if (tcdm_r_valid_i) begin
                        rsp_data_q <= tcdm_r_data_i;
                        if (op_q == OpLr) begin
                            resv_valid_q <= 1'b1;
                            resv_addr_q  <= addr_q[31:2];
                            exokay_q     <= 1'b1;
                            state_q      <= StAmoRsp;
                        end else begin
                            exokay_q <= 1'b0;
                            wdata_q  <= amo_new;
                            state_q  <= StAmoWr;
                        end
                    end
                end
                StAmoWr: begin
                    if (tcdm_gnt_i) begin
                        if (resv_valid_q && resv_addr_q == addr_q[31:2]) resv_valid_q <= 1'b0;
                        state_q <= StAmoWack;
                    end
                end
                StAmoWack: if (tcdm_r_valid_i) state_q <= StAmoRsp;
                StAmoRsp:  state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    // TCDM drive and core response; plain responses may overlap an atomic's first cycles.
    always_comb begin
        tcdm_req_o      = 1'b0;
        tcdm_add_o      = '0;
        tcdm_wen_o      = 1'b0;
        tcdm_be_o       = '0;
        tcdm_data_o     = '0;
        core_data_rsp_o = '0;
        unique case (state_q)
            StIdle: begin
                if (core_data_req_i.req && !req_err && is_plain) begin
                    tcdm_req_o          = 1'b1;
                    tcdm_add_o          = core_data_req_i.addr;
                    tcdm_wen_o          = !core_data_req_i.we;
                    tcdm_be_o           = core_data_req_i.be;
                    tcdm_data_o         = core_data_req_i.wdata;
                    core_data_rsp_o.gnt = tcdm_gnt_i;
                end else if (core_data_req_i.req) begin
                    core_data_rsp_o.gnt = 1'b1;
                end
            end
            StAmoRd: begin
                tcdm_req_o = 1'b1;
                tcdm_add_o = {addr_q[31:2], 2'b00};
                tcdm_wen_o = 1'b1;
                tcdm_be_o  = 4'hF;
            end
            StAmoWr: begin
                tcdm_req_o  = 1'b1;
                tcdm_add_o  = {addr_q[31:2], 2'b00};
                tcdm_wen_o  = 1'b0;
                tcdm_be_o   = 4'hF;
                tcdm_data_o = wdata_q;
            end
            default: ;
        endcase
        core_data_rsp_o.rvalid = (plain_pend_q && tcdm_r_valid_i) || err_pend_q ||
                                 (state_q == StAmoRsp);
        if (plain_pend_q)             core_data_rsp_o.rdata = tcdm_r_data_i;
        else if (state_q == StAmoRsp) core_data_rsp_o.rdata = rsp_data_q;
        core_data_rsp_o.err    = err_pend_q;
        core_data_rsp_o.exokay = (state_q == StAmoRsp) && exokay_q;
    end

endmodule

// File: tb/tb_core_data_amo_adapter.sv
// Randomised bench for core_data_amo_adapter with a transaction-level memory/reservation model
// and a behavioural TCDM that grants at random and answers one cycle after each grant.
module tb_core_data_amo_adapter;
    import redmule_tile_pkg::*;

    localparam logic [31:0] L1_BASE = 32'h1000_0000;
    localparam logic [31:0] L1_SIZE = 32'h0010_0000;

    logic           clk;
    logic           rst_n;
    core_data_req_t core_req;
    core_data_rsp_t core_rsp;
    logic           tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [31:0]    tcdm_add, tcdm_data, tcdm_r_data;
    logic [3:0]     tcdm_be;

    int total = 0;
    int bad   = 0;

    logic [31:0] tcdm_mem [logic [29:0]];
    logic [31:0] ref_mem  [logic [29:0]];
    logic        ref_resv_v = 1'b0;
    logic [29:0] ref_resv_k = '0;
    logic [5:0]  legal_atops [11];

    bit          rv_pend = 0;
    logic [31:0] rd_pend = '0;
    bit          gnt_script [$];
    logic [31:0] cur_addr;
    int          n_rd, n_wr;
    bit          addr_ok;
    int          last_gnt_lat;
    int          txn_id = 0;

    core_data_amo_adapter #(
        .L1_BASE(L1_BASE),
        .L1_SIZE(L1_SIZE),
        .RESV_EN(1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .core_data_req_i(core_req),
        .core_data_rsp_o(core_rsp),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tcdm_get(input logic [29:0] k);
        return tcdm_mem.exists(k) ? tcdm_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_get(input logic [29:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic mem_set(input logic [31:0] a, input logic [31:0] v);
        tcdm_mem[a[31:2]] = v;
        ref_mem[a[31:2]]  = v;
    endtask

    // Whole-transaction effect of one core request on memory and the reservation.
    task automatic model_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                             input logic [31:0] d, input logic [5:0] at,
                             output logic e, output logic [31:0] rdat, output logic chk_rd,
                             output logic exok, output int nrd, output int nwr);
        logic [29:0] k;
        logic [31:0] old, nw;
        bit          legal;
        k     = a[31:2];
        legal = (at == 6'h00);
        foreach (legal_atops[i]) if (at == legal_atops[i]) legal = 1;
        e      = ((a - L1_BASE) >= L1_SIZE) || !legal || (at != 6'h00 && (a[1:0] != 2'b00 || b != 4'hF));
        rdat   = '0;
        chk_rd = 1'b1;
        exok   = 1'b0;
        nrd    = 0;
        nwr    = 0;
        if (e) return;
        old = ref_get(k);
        if (at == 6'h00) begin
            if (w) begin
                nw = old;
                for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
                ref_mem[k] = nw;
                if (ref_resv_v && ref_resv_k == k) ref_resv_v = 1'b0;
                nwr    = 1;
                chk_rd = 1'b0;
            end else begin
                rdat = old;
                nrd  = 1;
            end
        end else if (at == 6'h22) begin
            rdat       = old;
            exok       = 1'b1;
            ref_resv_v = 1'b1;
            ref_resv_k = k;
            nrd        = 1;
        end else if (at == 6'h23) begin
            if (ref_resv_v && ref_resv_k == k) begin
                ref_mem[k] = d;
                exok       = 1'b1;
                nwr        = 1;
            end else begin
                rdat = 32'd1;
            end
            ref_resv_v = 1'b0;
        end else begin
            case (at)
                6'h20:   nw = old + d;
                6'h24:   nw = old ^ d;
                6'h28:   nw = old | d;
                6'h2C:   nw = old & d;
                6'h30:   nw = ($signed(old) < $signed(d)) ? old : d;
                6'h34:   nw = ($signed(old) > $signed(d)) ? old : d;
                6'h38:   nw = (old < d) ? old : d;
                6'h3C:   nw = (old > d) ? old : d;
                default: nw = d;
            endcase
            ref_mem[k] = nw;
            if (ref_resv_v && ref_resv_k == k) ref_resv_v = 1'b0;
            rdat = old;
            nrd  = 1;
            nwr  = 1;
        end
    endtask

    // One cycle of the TCDM model: deliver last cycle's response, pick a grant, serve the access.
    task automatic eval();
        logic [29:0] k;
        logic [31:0] tmp;
        tcdm_r_valid = rv_pend;
        tcdm_r_data  = rv_pend ? rd_pend : 32'h0;
        rv_pend      = 0;
        if (gnt_script.size() > 0) tcdm_gnt = gnt_script.pop_front();
        else                       tcdm_gnt = ($urandom_range(0, 3) != 0);
        #1;
        if (tcdm_req && tcdm_gnt) begin
            k = tcdm_add[31:2];
            if (k != cur_addr[31:2]) addr_ok = 0;
            if (tcdm_wen) begin
                n_rd++;
                rd_pend = tcdm_get(k);
            end else begin
                n_wr++;
                tmp = tcdm_get(k);
                for (int i = 0; i < 4; i++) if (tcdm_be[i]) tmp[8*i +: 8] = tcdm_data[8*i +: 8];
                tcdm_mem[k] = tmp;
                rd_pend     = 32'h0;
            end
            rv_pend = 1;
        end
    endtask

    // Issue one request (entered and left on a falling edge) and check it end to end.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input logic [5:0] at);
        logic        e, chk_rd, exp_exok, got_err, got_exok;
        logic [31:0] exp_rd, got_rd;
        int          exp_nrd, exp_nwr, gnt_lat, rsp_lat;
        bit          got_gnt, got_rsp, follow_ok, busy_ok, early_rv, plain, amo;
        string       t;
        model_txn(a, w, b, d, at, e, exp_rd, chk_rd, exp_exok, exp_nrd, exp_nwr);
        plain = !e && at == 6'h00;
        amo   = !e && at != 6'h00;
        t     = $sformatf("t%0d@%h/%h", txn_id, a, at);
        txn_id++;
        cur_addr = a;
        n_rd = 0; n_wr = 0; addr_ok = 1;
        got_gnt = 0; got_rsp = 0; follow_ok = 1; busy_ok = 1; early_rv = 0;
        gnt_lat = 0; rsp_lat = 0; got_rd = '0; got_err = 0; got_exok = 0;
        core_req       = '0;
        core_req.req   = 1'b1;
        core_req.addr  = a;
        core_req.we    = w;
        core_req.be    = b;
        core_req.wdata = d;
        core_req.atop  = at;
        for (int c = 0; c < 64 && !got_rsp; c++) begin
            eval();
            if (!got_gnt) begin
                if (plain && core_rsp.gnt !== tcdm_gnt) follow_ok = 0;
                if (core_rsp.rvalid) early_rv = 1;
                if (core_rsp.gnt) begin
                    got_gnt = 1;
                    gnt_lat = c;
                end
            end else begin
                if (amo && core_rsp.gnt) busy_ok = 0;
                if (core_rsp.rvalid) begin
                    got_rsp  = 1;
                    rsp_lat  = c - gnt_lat;
                    got_rd   = core_rsp.rdata;
                    got_err  = core_rsp.err;
                    got_exok = core_rsp.exokay;
                end
            end
            @(negedge clk);
            // While an atomic is in flight keep a request pending; it must not be granted
            if (got_gnt && amo && !got_rsp) begin
                core_req.addr = 32'h0000_0100;
                core_req.atop = 6'h00;
                core_req.we   = 1'b0;
            end else if (got_gnt) begin
                core_req.req = 1'b0;
            end
        end
        check({t, " responded"}, 32'(got_rsp), 1);
        check({t, " early_rvalid"}, 32'(early_rv), 0);
        check({t, " err"}, 32'(got_err), 32'(e));
        check({t, " exokay"}, 32'(got_exok), 32'(exp_exok));
        if (chk_rd) check({t, " rdata"}, got_rd, exp_rd);
        check({t, " tcdm_reads"}, n_rd, exp_nrd);
        check({t, " tcdm_writes"}, n_wr, exp_nwr);
        check({t, " tcdm_addr"}, 32'(addr_ok), 1);
        check({t, " mem"}, tcdm_get(a[31:2]), ref_get(a[31:2]));
        if (plain) begin
            check({t, " gnt_follows_tcdm"}, 32'(follow_ok), 1);
            check({t, " rsp_latency"}, rsp_lat, 1);
        end else begin
            check({t, " gnt_latency"}, gnt_lat, 0);
        end
        if (e)   check({t, " err_latency"}, rsp_lat, 1);
        if (amo) check({t, " gnt_while_busy"}, 32'(busy_ok), 1);
        last_gnt_lat = gnt_lat;
        eval();
        check({t, " extra_rvalid"}, 32'(core_rsp.rvalid), 0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string t);
        check({t, " tcdm_req"}, 32'(tcdm_req), 0);
        check({t, " tcdm_add"}, tcdm_add, 0);
        check({t, " tcdm_wen_be"}, {27'b0, tcdm_wen, tcdm_be}, 0);
        check({t, " tcdm_data"}, tcdm_data, 0);
        check({t, " core_gnt"}, 32'(core_rsp.gnt), 0);
        check({t, " core_rvalid"}, 32'(core_rsp.rvalid), 0);
        check({t, " core_rdata"}, core_rsp.rdata, 0);
        check({t, " core_err_exokay"}, {30'b0, core_rsp.err, core_rsp.exokay}, 0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [5:0]  at;
        logic [3:0]  b;
        int          r;
        legal_atops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h28,
                        6'h2C, 6'h30, 6'h34, 6'h38, 6'h3C};
        rst_n        = 1'b0;
        core_req     = '0;
        tcdm_gnt     = 1'b0;
        tcdm_r_valid = 1'b0;
        tcdm_r_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain store held off by two ungranted cycles, then read back
        gnt_script = '{0, 0, 1};
        do_txn(32'h1000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 6'h00);
        check("plain_store gnt_wait", last_gnt_lat, 2);
        do_txn(32'h1000_0010, 1'b0, 4'hF, 32'h0, 6'h00);

        // AMOADD wraps
        mem_set(32'h1000_0020, 32'hFFFF_FFFF);
        do_txn(32'h1000_0020, 1'b0, 4'hF, 32'd2, 6'h20);
        check("amoadd result", tcdm_get(30'h0400_0008), 32'h0000_0001);

        // Signed vs unsigned minimum
        mem_set(32'h1000_0030, 32'h8000_0000);
        do_txn(32'h1000_0030, 1'b0, 4'hF, 32'd1, 6'h30);
        check("amomin result", tcdm_get(30'h0400_000C), 32'h8000_0000);
        do_txn(32'h1000_0030, 1'b0, 4'hF, 32'd1, 6'h38);
        check("amominu result", tcdm_get(30'h0400_000C), 32'h0000_0001);

        // LR/SC success, then broken by an intervening store
        do_txn(32'h1000_0040, 1'b0, 4'hF, 32'h0, 6'h22);
        do_txn(32'h1000_0040, 1'b0, 4'hF, 32'h55, 6'h23);
        check("sc_ok mem", tcdm_get(30'h0400_0010), 32'h55);
        do_txn(32'h1000_0040, 1'b0, 4'hF, 32'h0, 6'h22);
        do_txn(32'h1000_0040, 1'b1, 4'hF, 32'h1234, 6'h00);
        do_txn(32'h1000_0040, 1'b0, 4'hF, 32'h66, 6'h23);

        // Local errors and window edges
        do_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 6'h00);
        do_txn(32'h1000_0002, 1'b0, 4'hF, 32'd1, 6'h20);
        do_txn(32'h1000_0010, 1'b0, 4'hF, 32'd1, 6'h05);
        do_txn(L1_BASE + L1_SIZE, 1'b0, 4'hF, 32'h0, 6'h00);
        do_txn(L1_BASE - 32'd4, 1'b1, 4'hF, 32'h0, 6'h00);
        do_txn(32'h100F_FFFC, 1'b1, 4'hF, 32'hA5A5_5A5A, 6'h00);
        do_txn(32'h1000_0010, 1'b0, 4'h7, 32'd1, 6'h21);

        // Reset while waiting on the atomic's read data
        do_txn(32'h1000_0080, 1'b0, 4'hF, 32'h0, 6'h22);
        cur_addr = 32'h1000_0080;
        n_rd = 0; n_wr = 0;
        core_req       = '0;
        core_req.req   = 1'b1;
        core_req.addr  = 32'h1000_0080;
        core_req.be    = 4'hF;
        core_req.wdata = 32'd5;
        core_req.atop  = 6'h20;
        gnt_script     = '{1, 1};
        eval();
        check("rst_amo accept", 32'(core_rsp.gnt), 1);
        @(negedge clk);
        core_req = '0;
        eval();
        @(negedge clk);
        check("rst_amo read_issued", n_rd, 1);
        rst_n   = 1'b0;
        rv_pend = 0;
        #1;
        check_idle_outputs("rst_amo");
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        ref_resv_v = 1'b0;
        @(negedge clk);
        do_txn(32'h1000_0080, 1'b0, 4'hF, 32'h77, 6'h23);
        do_txn(32'h1000_0080, 1'b0, 4'hF, 32'h0, 6'h00);

        // Randomised mix over a small word pool
        for (int i = 0; i < 8; i++) mem_set(32'h1000_1000 + 32'(4 * i), $urandom);
        mem_set(32'h100F_FFFC, $urandom);
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                8:       a = 32'h0000_0100;
                9:       a = L1_BASE + L1_SIZE;
                10:      a = 32'h100F_FFFC;
                11:      a = L1_BASE - 32'd4;
                default: a = 32'h1000_1000 + 32'(4 * r);
            endcase
            r = $urandom_range(0, 9);
            if (r < 5)      at = 6'h00;
            else if (r < 9) at = legal_atops[$urandom_range(0, 10)];
            else            at = 6'($urandom);
            if (at == 6'h23 && ref_resv_v && $urandom_range(0, 1) == 1) a = {ref_resv_k, 2'b00};
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if (at == 6'h00)                   b = 4'($urandom_range(1, 15));
            else if ($urandom_range(0, 9) == 0) b = 4'($urandom);
            else                               b = 4'hF;
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       d = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                1:       d = 32'($urandom_range(0, 3));
                default: ;
            endcase
            do_txn(a, 1'($urandom_range(0, 1)), b, d, at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_data_amo_adapter.md
Name: core_data_amo_adapter

Overview:
- Sits between the CV32E40X core data port (core_data_req_t / core_data_rsp_t from redmule_tile_pkg) and the core-side HCI TCDM port of the tile.
- Plain loads and stores pass through with no added latency.
- OBI atomics (atop) run as a read-then-write on the TCDM, with a single LR/SC reservation.
- Out-of-range addresses and illegal atomics get a local error response and generate no TCDM traffic.

Parameters:
- L1_BASE, 32'h1000_0000, base address of the L1 TCDM window.
- L1_SIZE, 32'h0010_0000, size in bytes of the L1 window.
- RESV_EN, 1, enables LR/SC. When 0, LR and SC are illegal atop values.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_data_req_i  in  core_data_req_t  core request (req, addr, atop, be, wdata, we; memtype, prot, dbg ignored)
- core_data_rsp_o  out  core_data_rsp_t  core response (gnt, rvalid, rdata, err, exokay)
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  32  TCDM byte address
- tcdm_wen_o  out  1  1 = read, 0 = write
- tcdm_be_o  out  4  byte enables
- tcdm_data_o  out  32  write data
- tcdm_r_data_i  in  32  read data
- tcdm_r_valid_i  in  1  response valid, exactly 1 cycle after each grant, for reads and writes

Behaviour:
- Reset: FSM=IDLE; reservation invalid; all pending flags 0; all outputs 0.
- Reset asserted mid-AMO aborts the operation. No core response is produced for it.
- In-range test: (addr - L1_BASE) < L1_SIZE, unsigned 32-bit.
- Legal atop values: 0 (plain access) or {1'b1, funct5} with funct5 one of:
  - ADD 00000, SWAP 00001, LR 00010, SC 00011
  - XOR 00100, OR 01000, AND 01100
  - MIN 10000, MAX 10100, MINU 11000, MAXU 11100
- Error condition: out of range; OR illegal atop; OR (atop != 0 AND (addr[1:0] != 0 OR be != 4'hF)).
- FSM states: IDLE, AMO_RD, AMO_WAIT, AMO_WR, AMO_WACK, AMO_RSP.
- IDLE, plain legal request:
  - Combinational pass-through: tcdm_req_o = req, tcdm_add_o = addr, tcdm_wen_o = ~we, be and data forwarded, gnt = tcdm_gnt_i.
  - On grant, set plain_pend.
  - The next cycle: rvalid = tcdm_r_valid_i, rdata = tcdm_r_data_i, err = 0, exokay = 0.
- IDLE, error request:
  - gnt = 1 in the same cycle; no TCDM request.
  - Next cycle: rvalid = 1, err = 1, rdata = 0.
- IDLE, legal AMO:
  - gnt = 1 (accept); capture addr, op, wdata.
  - SC: reservation valid and address matches goes to AMO_WR; otherwise goes to AMO_RSP with fail.
  - All other AMOs go to AMO_RD.
- Non-IDLE states: core gnt = 0.
- AMO_RD: tcdm_req = 1, wen = 1, be = F. On tcdm_gnt_i go to AMO_WAIT.
- AMO_WAIT: on tcdm_r_valid_i capture old = r_data.
  - LR: set reservation to addr[31:2], go to AMO_RSP.
  - Others: compute new, go to AMO_WR.
- AMO_WR: tcdm_req = 1, wen = 0, be = F, data = new (SC: wdata). On gnt go to AMO_WACK.
- AMO_WACK: wait tcdm_r_valid_i, which is absorbed and not forwarded. Go to AMO_RSP.
- AMO_RSP: one cycle of rvalid = 1, err = 0, then IDLE.
  - rdata: old for AMOs/LR; 0 on SC success; 1 on SC fail.
  - exokay = 1 for LR and successful SC, else 0.
- New value per op:
  - ADD: 32-bit wrap.
  - SWAP: wdata.
  - XOR / OR / AND: bitwise.
  - MIN / MAX: signed compare.
  - MINU / MAXU: unsigned compare.
- Reservation is cleared by:
  - any SC, whatever the outcome;
  - any granted plain store or AMO write to the reserved word;
  - reset.
- An LR that hits an existing reservation overwrites it.
- Ordering:
  - Only one request is accepted per cycle.
  - An AMO accepted the cycle after a plain grant cannot collide with that plain response, because plain responses are fixed at 1-cycle latency.
  - rvalid is never asserted for two transactions in one cycle.

Test Plan:
- Plain path: write 0xDEADBEEF to 0x1000_0010 with tcdm_gnt_i low for 2 cycles -> core gnt follows tcdm_gnt_i; read back the next cycle gives rdata 0xDEADBEEF, err 0.
- AMOADD: mem[0x1000_0020] = 0xFFFF_FFFF, wdata 2 -> core rdata 0xFFFF_FFFF; mem becomes 0x0000_0001; sequence is one TCDM read then one write; core gnt is low until AMO_RSP completes.
- AMOMIN vs AMOMINU: mem = 0x8000_0000, wdata 1 -> MIN leaves 0x8000_0000; MINU writes 1; both return 0x8000_0000.
- LR/SC: LR to 0x1000_0040 then SC of 0x55 -> exokay 1, rdata 0, mem = 0x55. Repeat with a plain store to 0x1000_0040 between LR and SC -> SC rdata 1, exokay 0, no TCDM write.
- Errors: read from 0x0000_0100 -> gnt the same cycle, rvalid+err the next cycle, rdata 0, no tcdm_req_o. AMOADD with addr 0x1000_0002 -> err. atop 6'h05 -> err.
- Reset in AMO_WAIT -> all outputs 0, FSM IDLE, reservation cleared; the next plain read completes normally.
